// File: rtl/gpregs_wb_arbiter.sv
// Writeback arbiter for the GPREGS write port: round-robin between the ALU (req0)
// and the load unit (req1), a registered write stage, and a per-register busy scoreboard.
module gpregs_wb_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_REGS       = 32
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      hold,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [REG_ADDR_WIDTH-1:0] req0_reg,
  input  logic [DATA_WIDTH-1:0]     req0_data,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [REG_ADDR_WIDTH-1:0] req1_reg,
  input  logic [DATA_WIDTH-1:0]     req1_data,
  input  logic                      rsv_valid,
  input  logic [REG_ADDR_WIDTH-1:0] rsv_reg,
  output logic [REG_ADDR_WIDTH-1:0] write_reg,
  output logic [DATA_WIDTH-1:0]     din,
  output logic                      din_enable,
  output logic [NUM_REGS-1:0]       busy
);

  logic                      ptr_q, ptr_d;
  logic [REG_ADDR_WIDTH-1:0] write_reg_q, write_reg_d;
  logic [DATA_WIDTH-1:0]     din_q, din_d;
  logic                      din_enable_q, din_enable_d;
  logic [NUM_REGS-1:0]       busy_q, busy_d;

  logic                      grant0_s, grant1_s, hs_s, sel_nz_s;
  logic [REG_ADDR_WIDTH-1:0] sel_reg_s;
  logic [DATA_WIDTH-1:0]     sel_data_s;
  logic [NUM_REGS-1:0]       set_mask_s, clr_mask_s;

  // Grant decision; ready is forced low while reset is asserted.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (nreset && !hold) begin
      if (req0_valid && req1_valid) begin
        if (ptr_q) begin
          grant1_s = 1'b1;
        end else begin
          grant0_s = 1'b1;
        end
      end else begin
        grant0_s = req0_valid;
        grant1_s = req1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Select the granted request's payload.
  always_comb begin
    hs_s = grant0_s | grant1_s;
    if (grant1_s) begin
      sel_reg_s  = req1_reg;
      sel_data_s = req1_data;
    end else begin
      sel_reg_s  = req0_reg;
      sel_data_s = req0_data;
    end
    sel_nz_s = (sel_reg_s != {REG_ADDR_WIDTH{1'b0}});
  end

  // Pointer next state: after a grant the other side is preferred.
  always_comb begin
    case ({grant1_s, grant0_s})
      2'b01:   ptr_d = 1'b1;
      2'b10:   ptr_d = 1'b0;
      default: ptr_d = ptr_q;
    endcase
  end

  // Write stage next state; address/data hold when idle, enable pulses one cycle.
  always_comb begin
    if (hs_s) begin
      write_reg_d  = sel_reg_s;
      din_d        = sel_data_s;
      din_enable_d = sel_nz_s;
    end else begin
      write_reg_d  = write_reg_q;
      din_d        = din_q;
      din_enable_d = 1'b0;
    end
  end

  // Scoreboard next state: a reservation wins over a same-cycle clear, x0 never busy.
  always_comb begin
    set_mask_s = {NUM_REGS{1'b0}};
    clr_mask_s = {NUM_REGS{1'b0}};
    if (rsv_valid) begin
      set_mask_s[rsv_reg] = 1'b1;
    end else begin
      set_mask_s = {NUM_REGS{1'b0}};
    end
    if (hs_s && sel_nz_s) begin
      clr_mask_s[sel_reg_s] = 1'b1;
    end else begin
      clr_mask_s = {NUM_REGS{1'b0}};
    end
    busy_d    = (busy_q & ~clr_mask_s) | set_mask_s;
    busy_d[0] = 1'b0;
  end

  // State registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ptr_q        <= 1'b0;
      write_reg_q  <= {REG_ADDR_WIDTH{1'b0}};
      din_q        <= {DATA_WIDTH{1'b0}};
      din_enable_q <= 1'b0;
      busy_q       <= {NUM_REGS{1'b0}};
    end else begin
      ptr_q        <= ptr_d;
      write_reg_q  <= write_reg_d;
      din_q        <= din_d;
      din_enable_q <= din_enable_d;
      busy_q       <= busy_d;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign write_reg  = write_reg_q;
  assign din        = din_q;
  assign din_enable = din_enable_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_gpregs_wb_arbiter.sv
// Bench for gpregs_wb_arbiter: a cycle model pushes the expected write of each
// cycle into a queue, popped and compared one cycle later on the falling edge.
module tb_gpregs_wb_arbiter;

  logic        clk;
  logic        nreset;
  logic        hold;
  logic        req0_valid, req0_ready;
  logic [4:0]  req0_reg;
  logic [31:0] req0_data;
  logic        req1_valid, req1_ready;
  logic [4:0]  req1_reg;
  logic [31:0] req1_data;
  logic        rsv_valid;
  logic [4:0]  rsv_reg;
  logic [4:0]  write_reg;
  logic [31:0] din;
  logic        din_enable;
  logic [31:0] busy;

  gpregs_wb_arbiter #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .NUM_REGS(32)) dut (
    .clk(clk), .nreset(nreset), .hold(hold),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_reg(req0_reg), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_reg(req1_reg), .req1_data(req1_data),
    .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
    .write_reg(write_reg), .din(din), .din_enable(din_enable), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  typedef struct packed {
    logic        en;
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         e_cur;
  wr_t         e_new;
  logic        m_ptr;
  logic [31:0] m_busy;
  logic        m_g0, m_g1;

  // Reference model and scoreboard, evaluated on the falling edge.
  always @(negedge clk) begin
    if (!nreset) begin
      m_ptr  = 1'b0;
      m_busy = 32'h0;
      exp_q.delete();
    end else begin
      e_cur = (exp_q.size() > 0) ? exp_q.pop_front() : 38'h0;
      check_eq("din_enable", 32'(din_enable), 32'(e_cur.en));
      if (e_cur.en) begin
        check_eq("write_reg", 32'(write_reg), 32'(e_cur.r));
        check_eq("din", din, e_cur.d);
      end
      check_eq("busy", busy, m_busy);

      m_g0 = 1'b0;
      m_g1 = 1'b0;
      if (!hold) begin
        if (req0_valid && req1_valid) begin
          m_g0 = (m_ptr == 1'b0);
          m_g1 = (m_ptr == 1'b1);
        end else begin
          m_g0 = req0_valid;
          m_g1 = req1_valid;
        end
      end
      check_eq("req0_ready", 32'(req0_ready), 32'(m_g0));
      check_eq("req1_ready", 32'(req1_ready), 32'(m_g1));

      e_new = 38'h0;
      if (m_g0) begin
        e_new.r = req0_reg; e_new.d = req0_data; m_ptr = 1'b1;
      end else if (m_g1) begin
        e_new.r = req1_reg; e_new.d = req1_data; m_ptr = 1'b0;
      end
      e_new.en = (m_g0 || m_g1) && (e_new.r != 5'd0);
      exp_q.push_back(e_new);
      if (e_new.en) m_busy[e_new.r] = 1'b0;
      if (rsv_valid && rsv_reg != 5'd0) m_busy[rsv_reg] = 1'b1;
    end
  end

  task automatic step(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                      input logic rv, input logic [4:0] rr, input logic h);
    req0_valid = v0; req0_reg = r0; req0_data = d0;
    req1_valid = v1; req1_reg = r1; req1_data = d1;
    rsv_valid  = rv; rsv_reg  = rr; hold = h;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
  endtask

  logic last_rdy0, last_rdy1;

  initial begin
    nreset = 1'b0;
    req0_valid = 1'b0; req0_reg = 5'd0; req0_data = 32'h0;
    req1_valid = 1'b0; req1_reg = 5'd0; req1_data = 32'h0;
    rsv_valid = 1'b0; rsv_reg = 5'd0; hold = 1'b0;
    #1;
    check_eq("rst_din_enable", 32'(din_enable), 32'h0);
    check_eq("rst_busy", busy, 32'h0);
    check_eq("rst_write_reg", 32'(write_reg), 32'h0);
    check_eq("rst_din", din, 32'h0);
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;

    // Single requester, then x0 write from req1
    step(1'b1, 5'd1, 32'h12, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    idle();
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 1'b0);
    idle();

    // Continuous contention
    repeat (4) step(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 1'b0, 5'd0, 1'b0);
    idle();

    // Scoreboard set / clear / set-beats-clear
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0);
    idle();
    step(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0);
    step(1'b1, 5'd5, 32'h56, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0);
    idle();
    step(1'b1, 5'd5, 32'h57, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    idle();

    // Reset in the middle of traffic
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0);
    step(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0);
    check_eq("pre_rst_din_enable", 32'(din_enable), 32'h1);
    check_eq("pre_rst_busy", busy, 32'h6);
    req0_valid = 1'b1; req0_reg = 5'd7; req0_data = 32'h77;
    req1_valid = 1'b1; req1_reg = 5'd8; req1_data = 32'h88;
    rsv_valid = 1'b0;
    nreset = 1'b0;
    #1;
    check_eq("mid_rst_din_enable", 32'(din_enable), 32'h0);
    check_eq("mid_rst_busy", busy, 32'h0);
    check_eq("mid_rst_req0_ready", 32'(req0_ready), 32'h0);
    check_eq("mid_rst_req1_ready", 32'(req1_ready), 32'h0);
    @(posedge clk); #1 nreset = 1'b1;
    #1;
    check_eq("post_rst_req0_ready", 32'(req0_ready), 32'h1);
    check_eq("post_rst_req1_ready", 32'(req1_ready), 32'h0);
    @(posedge clk); #1;
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 1'b0);
    idle();

    // Hold with both valid, then release
    repeat (3) step(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 1'b0, 5'd0, 1'b1);
    repeat (2) step(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 1'b0, 5'd0, 1'b0);
    idle();

    // Random traffic; a stalled requester keeps its request stable
    last_rdy0 = 1'b1;
    last_rdy1 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (!(req0_valid && !last_rdy0)) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_reg   = 5'($urandom_range(0, 7));
        req0_data  = $urandom;
      end
      if (!(req1_valid && !last_rdy1)) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_reg   = 5'($urandom_range(0, 7));
        req1_data  = $urandom;
      end
      rsv_valid = 1'($urandom_range(0, 1));
      rsv_reg   = 5'($urandom_range(0, 7));
      hold      = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      last_rdy0 = req0_ready;
      last_rdy1 = req1_ready;
      @(posedge clk); #1;
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
